// File: rtl/loop_stack_pkg.sv
// Shared constants for the loop-address stack; the CPU core reuses the
// address width, nesting depth and derived occupancy-count width.
package loop_stack_pkg;

  localparam int LS_ADDR_WIDTH  = 8;
  localparam int LS_DEPTH       = 16;
  localparam int LS_COUNT_WIDTH = $clog2(LS_DEPTH) + 1;

  // COUNT must hold the value DEPTH itself, hence the extra bit.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/loop_stack_if.sv
// Request/status bundle between the bracket decoder (master) and the
// loop stack (slave).
interface loop_stack_if
  import loop_stack_pkg::*;
#(
  parameter int ADDR_WIDTH = LS_ADDR_WIDTH,
  parameter int DEPTH      = LS_DEPTH
);

  localparam int CNT_W = count_width(DEPTH);

  logic                  PUSH;
  logic                  POP;
  logic [ADDR_WIDTH-1:0] D;
  logic [ADDR_WIDTH-1:0] Q;
  logic [CNT_W-1:0]      COUNT;
  logic                  EMPTY;
  logic                  FULL;
  logic                  OVERFLOW;
  logic                  UNDERFLOW;

  modport master (
    output PUSH, POP, D,
    input  Q, COUNT, EMPTY, FULL, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  PUSH, POP, D,
    output Q, COUNT, EMPTY, FULL, OVERFLOW, UNDERFLOW
  );

endinterface

// File: rtl/loop_stack_generic_counter.sv
// Generic up/down counter with synchronous load; used as the stack pointer.
module loop_stack_generic_counter #(
  parameter int WIDTH = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             DOWN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VALUE,
  output logic [WIDTH-1:0] CNT
);

  logic [WIDTH-1:0] cnt_r;

  // Count register: reset, then load, then step up or down when enabled.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (LOAD) begin
      cnt_r <= LOAD_VALUE;
    end else if (EN) begin
      if (DOWN) begin
        cnt_r <= cnt_r - WIDTH'(1);
      end else begin
        cnt_r <= cnt_r + WIDTH'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign CNT = cnt_r;

endmodule

// File: rtl/loop_stack.sv
// Loop-start address stack for the bracket-matching CPU: '[' pushes, ']'
// pops, both together replace the top. Q is a register, not an array read.
module loop_stack
  import loop_stack_pkg::*;
#(
  parameter int ADDR_WIDTH = LS_ADDR_WIDTH,
  parameter int DEPTH      = LS_DEPTH
) (
  input  logic         CLK,
  input  logic         RESET,
  loop_stack_if.slave  bus
);

  localparam int CNT_W = count_width(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] q_r;
  logic                  ovf_r;
  logic                  unf_r;

  logic [CNT_W-1:0]      count_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  pop_acc_s;
  logic                  push_acc_s;
  logic                  cnt_en_s;
  logic [IDX_W-1:0]      wr_idx_s;
  logic [ADDR_WIDTH-1:0] below_top_s;

  // Accept/reject decode. A pop on a non-empty stack is always accepted, and
  // an accepted pop makes room, so PUSH+POP on a full stack is a replace.
  always_comb begin
    empty_s     = (count_s == CNT_W'(0));
    full_s      = (count_s == CNT_W'(DEPTH));
    pop_acc_s   = bus.POP & ~empty_s;
    push_acc_s  = bus.PUSH & (~full_s | pop_acc_s);
    cnt_en_s    = push_acc_s ^ pop_acc_s;
    below_top_s = mem_r[IDX_W'(count_s - CNT_W'(2))];
    if (push_acc_s && pop_acc_s) begin
      wr_idx_s = IDX_W'(count_s - CNT_W'(1));
    end else begin
      wr_idx_s = IDX_W'(count_s);
    end
  end

  loop_stack_generic_counter #(
    .WIDTH (CNT_W)
  ) u_generic_counter (
    .CLK        (CLK),
    .RESET      (RESET),
    .EN         (cnt_en_s),
    .DOWN       (pop_acc_s),
    .LOAD       (1'b0),
    .LOAD_VALUE ({CNT_W{1'b0}}),
    .CNT        (count_s)
  );

  // Entry storage; intentionally not cleared, only the pointer is reset.
  always_ff @(posedge CLK) begin
    if (!RESET && push_acc_s) begin
      mem_r[wr_idx_s] <= bus.D;
    end
  end

  // Top-of-stack register and sticky error flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_r   <= {ADDR_WIDTH{1'b0}};
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (push_acc_s) begin
        q_r <= bus.D;
      end else if (pop_acc_s) begin
        q_r <= (count_s == CNT_W'(1)) ? {ADDR_WIDTH{1'b0}} : below_top_s;
      end else begin
        q_r <= q_r;
      end
      if (bus.PUSH && !bus.POP && full_s) begin
        ovf_r <= 1'b1;
      end else begin
        ovf_r <= ovf_r;
      end
      if (bus.POP && !bus.PUSH && empty_s) begin
        unf_r <= 1'b1;
      end else begin
        unf_r <= unf_r;
      end
    end
  end

  assign bus.Q         = q_r;
  assign bus.COUNT     = count_s;
  assign bus.EMPTY     = empty_s;
  assign bus.FULL      = full_s;
  assign bus.OVERFLOW  = ovf_r;
  assign bus.UNDERFLOW = unf_r;

endmodule

// File: doc/loop_stack.md
LOOP_STACK -- requirements
Module: loop_stack

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: width of stored program-counter values.
REQ-002 Parameter DEPTH, default 16: maximum loop nesting depth (power of two, at least 2).
REQ-003 CLK  input  1  the single clock; all state SHALL update on its rising edge only.
REQ-004 RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-005 PUSH  input  1  push D (loop-start address on '[').
REQ-006 POP  input  1  discard the top entry (loop exit on ']').
REQ-007 D  input  ADDR_WIDTH  address to push.
REQ-008 Q  output  ADDR_WIDTH  top-of-stack address, registered.
REQ-009 COUNT  output  clog2(DEPTH)+1  number of valid entries.
REQ-010 EMPTY  output  1  high when COUNT == 0.
REQ-011 FULL  output  1  high when COUNT == DEPTH.
REQ-012 OVERFLOW  output  1  sticky: a push was rejected because the stack was full.
REQ-013 UNDERFLOW  output  1  sticky: a pop was rejected because the stack was empty.

Function
REQ-014 Operations take effect at the rising edge where they are sampled, and the results SHALL be visible on Q, COUNT, EMPTY and FULL in the following cycle (latency 1); there is no ready/stall, and every request is accepted or rejected in that same cycle.
REQ-015 PUSH only, not full: store D above the top, COUNT+1, Q=D next cycle.
REQ-016 POP only, not empty: COUNT-1, Q = new top entry, or 0 if the stack becomes empty.
REQ-017 PUSH and POP together, not empty: replace the top entry with D, COUNT unchanged, Q=D next cycle.
REQ-018 PUSH and POP together, empty: treat as PUSH only; UNDERFLOW is not set.
REQ-019 PUSH only, full: stack and COUNT unchanged; OVERFLOW set.
REQ-020 PUSH and POP together, full: replace the top entry, as in REQ-017; OVERFLOW is not set.
REQ-021 POP only, empty: COUNT stays 0 (no wrap-around); Q stays 0; UNDERFLOW set.
REQ-022 Neither PUSH nor POP: all state held.
REQ-023 OVERFLOW and UNDERFLOW remain set until RESET; they do not affect later operations.
REQ-024 Q SHALL read 0 whenever EMPTY is high.
REQ-025 Stored entries below the top are never altered except by a push into that slot.

Reset
REQ-026 RESET with CLK edge: COUNT=0, Q=0, EMPTY=1, FULL=0, OVERFLOW=0, UNDERFLOW=0.
REQ-027 RESET SHALL take priority over simultaneous PUSH/POP; any operation in progress is discarded.
REQ-028 Storage array contents need not be cleared on reset; none are observable after reset.

Structure
REQ-029 Shared package holds: default ADDR_WIDTH, default DEPTH, and the derived COUNT width constant, all reused by the CPU core.
REQ-030 The stack pointer SHALL be one GenericCounter instance (WIDTH = COUNT width).
  - EN = accepted push XOR accepted pop.
  - DOWN = pop.
  - LOAD tied low.
  - RESET shared.
REQ-031 Storage is a DEPTH x ADDR_WIDTH register array, written at index COUNT (push) or COUNT-1 (replace).
REQ-032 Q is a separate output register, updated per REQ-015..REQ-017; it is not a combinational read of the array.

Verification
REQ-033 Reset, then push 0x10, 0x20, 0x30 on consecutive cycles -> Q = 0x10, 0x20, 0x30 one cycle after each push; COUNT=3; EMPTY=0.
REQ-034 From REQ-033, pop three times -> Q = 0x20, 0x10, 0; COUNT 2, 1, 0; EMPTY=1 after the last pop; UNDERFLOW=0.
REQ-035 Push DEPTH values 0..15, then push 0xAA -> FULL=1, OVERFLOW=1, Q=15, COUNT=16; then PUSH+POP with 0x55 -> Q=0x55, COUNT=16.
REQ-036 Pop on an empty stack -> UNDERFLOW=1, COUNT=0, Q=0; then PUSH+POP with 0x42 -> Q=0x42, COUNT=1.
REQ-037 Push 0x07, then PUSH+POP with 0x09 -> Q=0x09, COUNT=1; then pop -> EMPTY=1, Q=0.
REQ-038 Assert RESET in the same cycle as PUSH at COUNT=5 -> next cycle COUNT=0, Q=0, EMPTY=1, both sticky flags cleared.
